// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register. Also returns the MADD/MSUB accumulator state to EX.
// The {EX, MEM} stall pair selects advance, bubble or hold.
module ex_mem_reg #(
    parameter int DW      = 32,
    parameter int DDW     = 64,
    parameter int AW      = 5,
    parameter int SW      = 6,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [SW-1:0]  stall,
    input  logic [AW-1:0]  ex_desReg_addr,
    input  logic           ex_en_wd,
    input  logic [DW-1:0]  ex_result,
    input  logic           ex_en_hilo,
    input  logic [DW-1:0]  ex_hi,
    input  logic [DW-1:0]  ex_lo,
    input  logic [DDW-1:0] ex_hilo_tmp,
    input  logic [1:0]     ex_count,
    output logic [AW-1:0]  mem_desReg_addr,
    output logic           mem_en_wd,
    output logic [DW-1:0]  mem_result,
    output logic           mem_en_hilo,
    output logic [DW-1:0]  mem_hi,
    output logic [DW-1:0]  mem_lo,
    output logic [DDW-1:0] hilo_tmp_o,
    output logic [1:0]     count_o
);

    typedef enum logic [1:0] {
        MODE_ADVANCE = 2'b00,
        MODE_ILLEGAL = 2'b01,
        MODE_BUBBLE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    mode_t mode;
    logic  unused_stall;

    assign mode         = mode_t'({stall[EX_IDX], stall[MEM_IDX]});
    assign unused_stall = ^stall;

    // Anything other than advance or bubble holds, so the illegal code behaves like a hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_desReg_addr <= '0;
            mem_en_wd       <= 1'b0;
            mem_result      <= '0;
            mem_en_hilo     <= 1'b0;
            mem_hi          <= '0;
            mem_lo          <= '0;
            hilo_tmp_o      <= '0;
            count_o         <= '0;
        end else begin
            case (mode)
                MODE_ADVANCE: begin
                    mem_desReg_addr <= ex_desReg_addr;
                    mem_en_wd       <= ex_en_wd;
                    mem_result      <= ex_result;
                    mem_en_hilo     <= ex_en_hilo;
                    mem_hi          <= ex_hi;
                    mem_lo          <= ex_lo;
                    hilo_tmp_o      <= '0;
                    count_o         <= '0;
                end
                MODE_BUBBLE: begin
                    mem_desReg_addr <= '0;
                    mem_en_wd       <= 1'b0;
                    mem_result      <= '0;
                    mem_en_hilo     <= 1'b0;
                    mem_hi          <= '0;
                    mem_lo          <= '0;
                    hilo_tmp_o      <= ex_hilo_tmp;
                    count_o         <= ex_count;
                end
                default: begin
                end
            endcase
        end
    end

    // The stall controller never stalls MEM while letting EX run.
    illegal_stall_a : assert property (@(posedge clk) rst_n |-> (mode != MODE_ILLEGAL));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg. It includes hand-written sequences for the
// MADD hold case and for the registered-output check.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic [4:0]  ex_desReg_addr;
    logic        ex_en_wd;
    logic [31:0] ex_result;
    logic        ex_en_hilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] ex_hilo_tmp;
    logic [1:0]  ex_count;
    logic [4:0]  mem_desReg_addr;
    logic        mem_en_wd;
    logic [31:0] mem_result;
    logic        mem_en_hilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_tmp_o;
    logic [1:0]  count_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic        rst_n;
        logic [5:0]  stall;
        logic [4:0]  addr;
        logic        en_wd;
        logic [31:0] result;
        logic        en_hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] tmp;
        logic [1:0]  cnt;
    } stim_t;

    typedef struct {
        logic [4:0]  addr;
        logic        en_wd;
        logic [31:0] result;
        logic        en_hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] tmp;
        logic [1:0]  cnt;
    } out_t;

    typedef struct {
        stim_t s;
        out_t  e;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    ex_mem_reg dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .ex_desReg_addr  (ex_desReg_addr),
        .ex_en_wd        (ex_en_wd),
        .ex_result       (ex_result),
        .ex_en_hilo      (ex_en_hilo),
        .ex_hi           (ex_hi),
        .ex_lo           (ex_lo),
        .ex_hilo_tmp     (ex_hilo_tmp),
        .ex_count        (ex_count),
        .mem_desReg_addr (mem_desReg_addr),
        .mem_en_wd       (mem_en_wd),
        .mem_result      (mem_result),
        .mem_en_hilo     (mem_en_hilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .hilo_tmp_o      (hilo_tmp_o),
        .count_o         (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t ms(input logic r, input logic [5:0] st, input logic [4:0] a,
                                 input logic ew, input logic [31:0] res, input logic eh,
                                 input logic [31:0] h, input logic [31:0] l,
                                 input logic [63:0] t, input logic [1:0] c);
        stim_t s;
        s.rst_n = r; s.stall = st; s.addr = a; s.en_wd = ew; s.result = res;
        s.en_hilo = eh; s.hi = h; s.lo = l; s.tmp = t; s.cnt = c;
        return s;
    endfunction

    function automatic out_t mo(input logic [4:0] a, input logic ew, input logic [31:0] res,
                                input logic eh, input logic [31:0] h, input logic [31:0] l,
                                input logic [63:0] t, input logic [1:0] c);
        out_t o;
        o.addr = a; o.en_wd = ew; o.result = res; o.en_hilo = eh;
        o.hi = h; o.lo = l; o.tmp = t; o.cnt = c;
        return o;
    endfunction

    task automatic checkField(input string tag, input string name,
                              input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input out_t e);
        checkField(tag, "mem_desReg_addr", 64'(mem_desReg_addr), 64'(e.addr));
        checkField(tag, "mem_en_wd",       64'(mem_en_wd),       64'(e.en_wd));
        checkField(tag, "mem_result",      64'(mem_result),      64'(e.result));
        checkField(tag, "mem_en_hilo",     64'(mem_en_hilo),     64'(e.en_hilo));
        checkField(tag, "mem_hi",          64'(mem_hi),          64'(e.hi));
        checkField(tag, "mem_lo",          64'(mem_lo),          64'(e.lo));
        checkField(tag, "hilo_tmp_o",      hilo_tmp_o,           e.tmp);
        checkField(tag, "count_o",         64'(count_o),         64'(e.cnt));
    endtask

    // Drive away from the active edge, then sample just after it.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst_n          = s.rst_n;
        stall          = s.stall;
        ex_desReg_addr = s.addr;
        ex_en_wd       = s.en_wd;
        ex_result      = s.result;
        ex_en_hilo     = s.en_hilo;
        ex_hi          = s.hi;
        ex_lo          = s.lo;
        ex_hilo_tmp    = s.tmp;
        ex_count       = s.cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 6'b0;
        ex_desReg_addr = '0;
        ex_en_wd       = 1'b0;
        ex_result      = '0;
        ex_en_hilo     = 1'b0;
        ex_hi          = '0;
        ex_lo          = '0;
        ex_hilo_tmp    = '0;
        ex_count       = '0;

        vecs[0]  = '{ms(0, 6'b000000, 31, 1, 32'h1111_1111, 1, 32'h2222_2222, 32'h3333_3333, 64'hAAAA_BBBB_CCCC_DDDD, 2),
                     mo(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{ms(1, 6'b000000, 31, 1, 32'h1111_1111, 1, 32'h2222_2222, 32'h3333_3333, 64'hAAAA_BBBB_CCCC_DDDD, 2),
                     mo(31, 1, 32'h1111_1111, 1, 32'h2222_2222, 32'h3333_3333, 0, 0)};
        vecs[2]  = '{ms(1, 6'b000000, 7, 1, 32'hDEAD_BEEF, 0, 0, 0, 64'h55, 3),
                     mo(7, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0)};
        vecs[3]  = '{ms(1, 6'b001111, 9, 1, 32'h1234_5678, 1, 32'h44, 32'h55, 64'h1_0000_0002, 1),
                     mo(0, 0, 0, 0, 0, 0, 64'h1_0000_0002, 1)};
        vecs[4]  = '{ms(1, 6'b011111, 10, 1, 32'hAAAA_0001, 1, 32'h66, 32'h77, 64'h9999, 2),
                     mo(0, 0, 0, 0, 0, 0, 64'h1_0000_0002, 1)};
        vecs[5]  = '{ms(1, 6'b011111, 11, 0, 32'hAAAA_0002, 1, 32'h88, 32'h99, 64'h8888, 3),
                     mo(0, 0, 0, 0, 0, 0, 64'h1_0000_0002, 1)};
        vecs[6]  = '{ms(1, 6'b011111, 12, 1, 32'hAAAA_0003, 0, 0, 1, 64'h7777, 0),
                     mo(0, 0, 0, 0, 0, 0, 64'h1_0000_0002, 1)};
        vecs[7]  = '{ms(1, 6'b000000, 3, 1, 32'hCAFE_F00D, 1, 32'h77, 32'h88, 64'h6666, 1),
                     mo(3, 1, 32'hCAFE_F00D, 1, 32'h77, 32'h88, 0, 0)};
        vecs[8]  = '{ms(1, 6'b011111, 20, 0, 32'h0BAD_0BAD, 0, 32'h11, 32'h22, 64'h5555, 2),
                     mo(3, 1, 32'hCAFE_F00D, 1, 32'h77, 32'h88, 0, 0)};
        vecs[9]  = '{ms(1, 6'b001111, 0, 0, 0, 0, 0, 0, 64'h1_0000_0005, 1),
                     mo(0, 0, 0, 0, 0, 0, 64'h1_0000_0005, 1)};
        vecs[10] = '{ms(1, 6'b000000, 0, 0, 0, 1, 32'h1, 32'h5, 64'h1_0000_0005, 1),
                     mo(0, 0, 0, 1, 32'h1, 32'h5, 0, 0)};
        vecs[11] = '{ms(1, 6'b001111, 0, 0, 0, 1, 0, 0, 64'hFFFF_0000_1234_5678, 1),
                     mo(0, 0, 0, 0, 0, 0, 64'hFFFF_0000_1234_5678, 1)};
        vecs[12] = '{ms(0, 6'b001111, 5, 1, 32'h1, 1, 32'h1, 32'h1, 64'h1, 1),
                     mo(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[13] = '{ms(0, 6'b011111, 5, 1, 32'h1, 1, 32'h1, 32'h1, 64'h1, 1),
                     mo(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[14] = '{ms(1, 6'b000000, 4, 1, 32'h00C0_FFEE, 0, 0, 0, 0, 0),
                     mo(4, 1, 32'h00C0_FFEE, 0, 0, 0, 0, 0)};

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].e);
        end

        // The MADD step-2 hold must keep the partial product and count until the advance.
        applyStimulus(ms(1, 6'b001111, 1, 0, 32'h1, 0, 0, 0, 64'h2_0000_0003, 1));
        checkOutput("madd_bubble", mo(0, 0, 0, 0, 0, 0, 64'h2_0000_0003, 1));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(ms(1, 6'b011111, 5'(k + 2), 1, 32'h5000 + k, 1, 32'hF0 + k, 32'hE0 + k,
                             64'h7_0000_0000 + k, 2'(k + 2)));
            checkOutput($sformatf("madd_hold%0d", k), mo(0, 0, 0, 0, 0, 0, 64'h2_0000_0003, 1));
        end
        applyStimulus(ms(1, 6'b000000, 0, 0, 0, 1, 32'h2, 32'h8, 64'h2_0000_0003, 1));
        checkOutput("madd_final", mo(0, 0, 0, 1, 32'h2, 32'h8, 0, 0));

        // Inputs changed mid-cycle must not show up before the next edge.
        @(negedge clk);
        ex_result      = 32'h7777_7777;
        ex_en_wd       = 1'b1;
        ex_desReg_addr = 5'd30;
        #2;
        checkField("no_comb", "mem_result", 64'(mem_result), 64'h0);
        checkField("no_comb", "mem_en_wd",  64'(mem_en_wd),  64'h0);
        @(posedge clk);
        #1;
        checkField("after_edge", "mem_result",      64'(mem_result),      64'h7777_7777);
        checkField("after_edge", "mem_desReg_addr", 64'(mem_desReg_addr), 64'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
